// File: rtl/digit_scan_controller.sv
// Four-digit multiplexed display scanner with registered outputs.
// Optional inter-digit blanking is built in when DIGIT_SCAN_BLANK_EN is defined.
module digit_scan_controller #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [3:0] selector,
  output logic [3:0] anode,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);

`ifdef DIGIT_SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    BLANK
  } state_t;
`else
  localparam int unused_blank_cycles = BLANK_CYCLES;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_d;
  logic [3:0]    sel_d;
  logic [3:0]    an_d;
  logic          fd_d;
  logic          adv;

  // State, dwell counter and all outputs are registered together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      digit_idx  <= '0;
      selector   <= '0;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_idx  <= idx_d;
      selector   <= sel_d;
      anode      <= an_d;
      frame_done <= fd_d;
    end
  end

  // Next state and next registered outputs; adv moves to the next digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = digit_idx;
    sel_d   = selector;
    an_d    = anode;
    fd_d    = 1'b0;
    adv     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      sel_d   = '0;
      an_d    = '1;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = DRIVE;
          cnt_d   = '0;
          idx_d   = '0;
          sel_d   = 4'b0001;
          an_d    = 4'b1110;
        end
        DRIVE: begin
          if (cnt_q == DRIVE_LAST) begin
`ifdef DIGIT_SCAN_BLANK_EN
            state_d = BLANK;
            cnt_d   = '0;
            an_d    = 4'b1111;
`else
            adv     = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef DIGIT_SCAN_BLANK_EN
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            adv = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          sel_d   = '0;
          an_d    = '1;
        end
      endcase
      if (adv) begin
        state_d = DRIVE;
        cnt_d   = '0;
        idx_d   = digit_idx + 2'd1;
        sel_d   = 4'b0001 << idx_d;
        an_d    = ~sel_d;
        fd_d    = (digit_idx == 2'd3);
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_controller.sv
// Bench for digit_scan_controller: directed tables, corner sequences,
// and random enable toggling against a frame-position reference model.
module tb_digit_scan_controller;

  localparam int CD = 4;
  localparam int BC = 2;
`ifdef DIGIT_SCAN_BLANK_EN
  localparam int BL = BC;
  localparam int RST_T = 3 * (CD + BC) + CD;
`else
  localparam int BL = 0;
  localparam int RST_T = 3 * CD + 1;
`endif
  localparam int SLOT  = CD + BL;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] selector;
  logic [3:0] anode;
  logic [1:0] digit_idx;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  digit_scan_controller #(
    .CLK_DIV     (CD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .selector  (selector),
    .anode     (anode),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference: m_t counts edges since scanning started
  logic m_act;
  int   m_t;
  int   en_run;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_act  <= 1'b0;
      m_t    <= 0;
      en_run <= 0;
    end else if (enable) begin
      en_run <= en_run + 1;
      if (!m_act) begin
        m_act <= 1'b1;
        m_t   <= 0;
      end else begin
        m_t <= m_t + 1;
      end
    end else begin
      m_act  <= 1'b0;
      m_t    <= 0;
      en_run <= 0;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    int p, dg, ph;
    logic [3:0] e_sel, e_an;
    logic [1:0] e_idx;
    logic e_fd;
    p  = m_t % FRAME;
    dg = p / SLOT;
    ph = p % SLOT;
    e_sel = m_act ? (4'b0001 << dg) : 4'b0000;
    e_an  = (m_act && ph < CD) ? ~e_sel : 4'b1111;
    e_idx = m_act ? 2'(dg) : 2'd0;
    e_fd  = m_act && m_t >= FRAME && p == 0;
    chk("model_sel", {4'h0, selector}, {4'h0, e_sel});
    chk("model_anode", {4'h0, anode}, {4'h0, e_an});
    chk("model_idx", {6'h0, digit_idx}, {6'h0, e_idx});
    chk("model_fd", {7'h0, frame_done}, {7'h0, e_fd});
    chk("onecold_anode", 8'($countones(~anode) <= 1), 8'd1);
    chk("onehot_sel", 8'($countones(selector) <= 1), 8'd1);
  endtask

  task automatic step(input logic en);
    enable = en;
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  typedef struct {
    int         n;
    logic [3:0] an;
    logic       fd;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int last_fd, npulse;
    logic en;

`ifdef DIGIT_SCAN_BLANK_EN
    tbl.push_back('{4, 4'hE, 1'b0});
    tbl.push_back('{2, 4'hF, 1'b0});
    tbl.push_back('{4, 4'hD, 1'b0});
    tbl.push_back('{2, 4'hF, 1'b0});
    tbl.push_back('{4, 4'hB, 1'b0});
    tbl.push_back('{2, 4'hF, 1'b0});
    tbl.push_back('{4, 4'h7, 1'b0});
    tbl.push_back('{2, 4'hF, 1'b0});
`else
    tbl.push_back('{4, 4'hE, 1'b0});
    tbl.push_back('{4, 4'hD, 1'b0});
    tbl.push_back('{4, 4'hB, 1'b0});
    tbl.push_back('{4, 4'h7, 1'b0});
`endif
    tbl.push_back('{1, 4'hE, 1'b1});
    tbl.push_back('{3, 4'hE, 1'b0});

    reset_n = 1'b0;
    enable  = 1'b0;
    @(negedge clk);

    // Held in reset with enable high: dark
    repeat (3) begin
      step(1'b1);
      chk("rst_sel", {4'h0, selector}, 8'h00);
      chk("rst_anode", {4'h0, anode}, 8'h0F);
    end
    reset_n = 1'b1;

    // One full frame plus the wrap, table driven
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(1'b1);
        chk("tbl_anode", {4'h0, anode}, {4'h0, tbl[i].an});
        chk("tbl_fd", {7'h0, frame_done}, {7'h0, tbl[i].fd});
        if (i == 0 && k == 0)
          chk("first_sel", {4'h0, selector}, 8'h01);
      end
    end

    // Frame period between consecutive pulses
    last_fd = -1;
    npulse  = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      step(1'b1);
`ifndef DIGIT_SCAN_BLANK_EN
      if (anode == 4'hF)
        chk("noblank_dark", {4'h0, anode}, 8'h0E);
`endif
      if (frame_done) begin
        if (last_fd >= 0)
          chk("period", 8'(c - last_fd), 8'(FRAME));
        last_fd = c;
        npulse++;
      end
    end
    chk("pulse_count", 8'(npulse), 8'd2);

    // Drop enable in the middle of digit 2
    step(1'b0);
    step(1'b1);
    repeat (2 * SLOT + 1) step(1'b1);
    chk("mid_idx", {6'h0, digit_idx}, 8'h02);
    step(1'b0);
    chk("dis_sel", {4'h0, selector}, 8'h00);
    chk("dis_anode", {4'h0, anode}, 8'h0F);
    chk("dis_idx", {6'h0, digit_idx}, 8'h00);
    chk("dis_fd", {7'h0, frame_done}, 8'h00);
    repeat (CD) begin
      step(1'b1);
      chk("re_anode", {4'h0, anode}, 8'h0E);
      chk("re_sel", {4'h0, selector}, 8'h01);
      chk("re_fd", {7'h0, frame_done}, 8'h00);
    end

    // Asynchronous reset late in digit 3
    step(1'b0);
    step(1'b1);
    repeat (RST_T) step(1'b1);
    chk("pre_rst_idx", {6'h0, digit_idx}, 8'h03);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sel", {4'h0, selector}, 8'h00);
    chk("arst_anode", {4'h0, anode}, 8'h0F);
    chk("arst_idx", {6'h0, digit_idx}, 8'h00);
    chk("arst_fd", {7'h0, frame_done}, 8'h00);
    compare();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (FRAME) begin
      step(1'b1);
      chk("post_rst_fd", {7'h0, frame_done}, 8'h00);
    end

    // Random enable toggling
    for (int c = 0; c < 1000; c++) begin
      en = ($urandom_range(0, 63) != 0);
      step(en);
      if (frame_done)
        chk("frame_whole",
            8'(en_run > FRAME && (en_run - 1) % FRAME == 0), 8'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
